// File: rtl/display_scan_ctrl_if.sv
// Shared types for the front-panel display scan controller: the clock/reset
// bundle and the t_display pin group driven toward the LED drivers.
`timescale 1ns/1ps

package display_scan_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

interface t_display;
  logic       latch;
  logic       blank;
  logic [2:0] csel;
  logic       sclk;
  logic       sin;

  modport producer (output latch, blank, csel, sclk, sin);
  modport consumer (input  latch, blank, csel, sclk, sin);
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed LED-display scan controller. Holds a double-buffered frame of
// column words, shifts each column MSB-first into the drivers, latches it and
// steps csel. Every display output comes straight from a flop.
`timescale 1ns/1ps

module display_scan_ctrl
  import display_scan_pkg::*;
#(
  parameter int NUM_COLS     = 8,
  parameter int BITS_PER_COL = 16,
  parameter int SCLK_DIV     = 2,
  parameter int DWELL_CYCLES = 1000,
  parameter int LATCH_CYCLES = 2
) (
  input  ckrs_t                   ClkRs_ix,
  input  logic                    enable_i,
  input  logic                    wr_en_i,
  input  logic [2:0]              wr_addr_ib,
  input  logic [BITS_PER_COL-1:0] wr_data_ib,
  input  logic                    swap_req_i,
  output logic                    swap_ack_o,
  output logic                    frame_start_o,
  t_display.producer              Display_ox
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int PW = $clog2(2 * SCLK_DIV + 1);
  localparam int BW = $clog2(BITS_PER_COL + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [3:0]    NCOLS4     = 4'(NUM_COLS);
  localparam logic [2:0]    NC_LAST    = 3'(NUM_COLS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(2 * SCLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH    = PW'(SCLK_DIV);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_COL - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  if (DWELL_CYCLES < 2 * SCLK_DIV * BITS_PER_COL) begin : g_dwell_chk
    $error("DWELL_CYCLES shorter than one full column shift");
  end
  if (NUM_COLS < 2 || NUM_COLS > 8) begin : g_cols_chk
    $error("NUM_COLS must be within 2..8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WAIT, S_PRE_BLANK, S_LATCH, S_POST_BLANK
  } state_t;

  logic clk, rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  // Two frame buffers; act selects the one being displayed, the other is the back buffer.
  logic [BITS_PER_COL-1:0] mem [2][8];

  state_t                  state, state_n;
  logic                    act, act_n, pending, pending_n, shown, shown_n;
  logic [2:0]              nc, nc_n, csel, csel_n;
  logic [BITS_PER_COL-1:0] shreg, shreg_n;
  logic [DW-1:0]           dwell, dwell_n;
  logic [PW-1:0]           ph, ph_n;
  logic [BW-1:0]           bitc, bitc_n;
  logic [LW-1:0]           lcnt, lcnt_n;
  logic                    blank_q, latch_q, sclk_q, sin_q, ack_q, fs_q;
  logic                    blank_n, latch_n, sclk_n, sin_n, ack_n, fs_n;
  logic                    enter, swap, wr_ok;

  assign wr_ok = wr_en_i && ({1'b0, wr_addr_ib} < NCOLS4);

  // Next-state, column sequencing, swap handling and next output values.
  always_comb begin
    state_n   = state;
    nc_n      = nc;
    csel_n    = csel;
    shown_n   = shown;
    act_n     = act;
    pending_n = pending | swap_req_i;
    shreg_n   = shreg;
    dwell_n   = dwell;
    ph_n      = ph;
    bitc_n    = bitc;
    lcnt_n    = lcnt;
    ack_n     = 1'b0;
    fs_n      = 1'b0;
    enter     = 1'b0;
    swap      = 1'b0;
    if (!enable_i) begin
      state_n = S_IDLE;
      shown_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          nc_n    = 3'd0;
          state_n = S_SHIFT;
          enter   = 1'b1;
        end
        S_SHIFT: begin
          dwell_n = dwell + DW'(1);
          if (ph == PH_LAST) begin
            ph_n = '0;
            if (bitc == BIT_LAST) begin
              state_n = S_WAIT;
            end else begin
              bitc_n  = bitc + BW'(1);
              shreg_n = shreg << 1;
            end
          end else begin
            ph_n = ph + PW'(1);
          end
          // A dwell equal to the shift length ends the column right here.
          if (dwell == DWELL_LAST) state_n = S_PRE_BLANK;
        end
        S_WAIT: begin
          dwell_n = dwell + DW'(1);
          if (dwell == DWELL_LAST) state_n = S_PRE_BLANK;
        end
        S_PRE_BLANK: begin
          lcnt_n  = '0;
          state_n = S_LATCH;
        end
        S_LATCH: begin
          if (lcnt == LATCH_LAST) begin
            csel_n  = nc;
            shown_n = 1'b1;
            nc_n    = (nc == NC_LAST) ? 3'd0 : nc + 3'd1;
            state_n = S_POST_BLANK;
          end else begin
            lcnt_n = lcnt + LW'(1);
          end
        end
        S_POST_BLANK: begin
          state_n = S_SHIFT;
          enter   = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
      if (enter) begin
        swap    = (nc_n == 3'd0) && (pending || swap_req_i);
        fs_n    = (nc_n == 3'd0);
        dwell_n = '0;
        ph_n    = '0;
        bitc_n  = '0;
        if (swap) begin
          act_n     = ~act;
          pending_n = 1'b0;
          ack_n     = 1'b1;
        end
        // A write landing in the swap cycle targets the buffer that just became active.
        if (swap && wr_ok && (wr_addr_ib == nc_n)) shreg_n = wr_data_ib;
        else                                       shreg_n = mem[act_n][nc_n];
      end
    end
    sclk_n  = (state_n == S_SHIFT) && (ph_n >= PH_HIGH);
    sin_n   = (state_n == S_SHIFT) && shreg_n[BITS_PER_COL-1];
    latch_n = (state_n == S_LATCH);
    blank_n = !(((state_n == S_SHIFT) || (state_n == S_WAIT)) && shown_n);
  end

  // Control state and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      nc      <= 3'd0;
      csel    <= 3'd0;
      shown   <= 1'b0;
      act     <= 1'b0;
      pending <= 1'b0;
      shreg   <= '0;
      dwell   <= '0;
      ph      <= '0;
      bitc    <= '0;
      lcnt    <= '0;
      blank_q <= 1'b1;
      latch_q <= 1'b0;
      sclk_q  <= 1'b0;
      sin_q   <= 1'b0;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state   <= state_n;
      nc      <= nc_n;
      csel    <= csel_n;
      shown   <= shown_n;
      act     <= act_n;
      pending <= pending_n;
      shreg   <= shreg_n;
      dwell   <= dwell_n;
      ph      <= ph_n;
      bitc    <= bitc_n;
      lcnt    <= lcnt_n;
      blank_q <= blank_n;
      latch_q <= latch_n;
      sclk_q  <= sclk_n;
      sin_q   <= sin_n;
      ack_q   <= ack_n;
      fs_q    <= fs_n;
    end
  end

  // Host writes always go to the back buffer; reset clears both buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 8; c++)
          mem[b][c] <= '0;
    end else if (wr_ok) begin
      mem[~act][wr_addr_ib] <= wr_data_ib;
    end
  end

  assign Display_ox.latch = latch_q;
  assign Display_ox.blank = blank_q;
  assign Display_ox.csel  = csel;
  assign Display_ox.sclk  = sclk_q;
  assign Display_ox.sin   = sin_q;
  assign swap_ack_o       = ack_q;
  assign frame_start_o    = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: random and directed stimulus checked every
// cycle against a column-timeline model of the scan behaviour.
`timescale 1ns/1ps

module tb_display_scan_ctrl;
  import display_scan_pkg::*;

  localparam int P_COLS  = 6;
  localparam int P_BITS  = 16;
  localparam int P_DIV   = 2;
  localparam int P_DWELL = 80;
  localparam int P_LATCH = 2;
  localparam int P_PER   = P_DWELL + P_LATCH + 2;
  localparam int P_SHIFT = 2 * P_DIV * P_BITS;

  logic        clk = 1'b0;
  logic        rst, en, wr, req;
  logic [2:0]  addr;
  logic [15:0] data;
  logic        swap_ack, frame_start;
  ckrs_t       ckrs;

  assign ckrs.clk   = clk;
  assign ckrs.reset = rst;

  t_display disp();

  display_scan_ctrl #(
    .NUM_COLS(P_COLS), .BITS_PER_COL(P_BITS), .SCLK_DIV(P_DIV),
    .DWELL_CYCLES(P_DWELL), .LATCH_CYCLES(P_LATCH)
  ) dut (
    .ClkRs_ix(ckrs), .enable_i(en), .wr_en_i(wr), .wr_addr_ib(addr),
    .wr_data_ib(data), .swap_req_i(req), .swap_ack_o(swap_ack),
    .frame_start_o(frame_start), .Display_ox(disp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position t within the current column period and the column index.
  bit          m_run, m_shown, m_pend, m_act, m_ack, m_fs;
  int          m_t, m_col, m_csel;
  logic [15:0] m_word;
  logic [15:0] m_mem [2][8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit swapped, enter, old_act;
    swapped = 0; enter = 0; old_act = m_act;
    m_ack = 0; m_fs = 0;
    if (rst) begin
      m_run = 0; m_t = 0; m_col = 0; m_csel = 0; m_shown = 0;
      m_pend = 0; m_act = 0; m_word = '0;
      foreach (m_mem[b, c]) m_mem[b][c] = '0;
      return;
    end
    if (!en) begin
      m_run = 0; m_shown = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0; m_col = 0; enter = 1;
    end else begin
      m_t++;
      if (m_t == P_PER) begin
        m_t = 0; m_col = (m_col + 1) % P_COLS; enter = 1;
      end else if (m_t == P_DWELL + P_LATCH + 1) begin
        m_csel = m_col; m_shown = 1;
      end
    end
    if (enter) begin
      m_fs = (m_col == 0);
      if (m_col == 0 && (m_pend || req)) begin
        m_act = !m_act; m_ack = 1; m_pend = 0; swapped = 1;
      end
      m_word = (swapped && wr && int'(addr) == m_col) ? data : m_mem[m_act][m_col];
    end
    if (req && !swapped) m_pend = 1;
    if (wr && int'(addr) < P_COLS) m_mem[!old_act][addr] = data;
  endtask

  task automatic compare_outputs();
    logic e_blank, e_latch, e_sclk, e_sin;
    if (!m_run) begin
      e_blank = 1; e_latch = 0; e_sclk = 0; e_sin = 0;
    end else begin
      e_sclk = 0; e_sin = 0;
      if (m_t < P_SHIFT) begin
        e_sclk = (m_t % (2 * P_DIV)) >= P_DIV;
        e_sin  = m_word[P_BITS - 1 - m_t / (2 * P_DIV)];
      end
      e_latch = (m_t > P_DWELL) && (m_t <= P_DWELL + P_LATCH);
      e_blank = (m_t >= P_DWELL) || !m_shown;
    end
    chk("blank", 32'(disp.blank), 32'(e_blank));
    chk("latch", 32'(disp.latch), 32'(e_latch));
    chk("sclk",  32'(disp.sclk),  32'(e_sclk));
    chk("sin",   32'(disp.sin),   32'(e_sin));
    chk("csel",  32'(disp.csel),  32'(m_csel));
    chk("swap_ack",    32'(swap_ack),    32'(m_ack));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  // Advance until the model reaches column col (any if negative) at offset t.
  task automatic wait_pos(input int col, input int t, input string tag);
    int n = 0;
    while (!(m_run && (col < 0 || m_col == col) && m_t == t) && n < 2 * P_COLS * P_PER) begin
      cycle();
      n++;
    end
    chk(tag, 32'(m_run && (col < 0 || m_col == col) && m_t == t), 32'd1);
  endtask

  initial begin
    int n, acks, rises;
    logic prev, sin_any;
    logic [2:0]  held_csel;
    logic [15:0] word;

    rst = 1; en = 0; wr = 0; req = 0; addr = '0; data = '0;
    repeat (3) cycle();
    rst = 0;

    // Fill the back buffer (addresses 6 and 7 lie beyond NUM_COLS).
    for (int i = 0; i < 8; i++) begin
      wr = 1; addr = 3'(i); data = 16'h8001 + 16'(i);
      cycle();
    end
    wr = 0; req = 1; cycle(); req = 0;
    en = 1; cycle();
    chk("first_ack_fs", {30'd0, swap_ack, frame_start}, 32'd3);

    n = 0;
    while (!disp.latch && n < 200) begin cycle(); n++; end
    chk("latch_offset", 32'(n), 32'(P_DWELL + 1));
    cycle(); chk("latch_2nd", 32'(disp.latch), 32'd1);
    cycle(); chk("latch_end", 32'(disp.latch), 32'd0);
    chk("csel_after_latch", 32'(disp.csel), 32'd0);
    cycle(); chk("blank_shown", 32'(disp.blank), 32'd0);

    n = 0;
    while (!frame_start && n < 2 * P_COLS * P_PER) begin cycle(); n++; end
    n = 0;
    do begin cycle(); n++; end while (!frame_start && n < 2 * P_COLS * P_PER);
    chk("frame_period", 32'(n), 32'(P_COLS * P_PER));

    // New back-buffer contents, then three swap requests inside one frame.
    for (int i = 0; i < P_COLS; i++) begin
      wr = 1; addr = 3'(i); data = 16'h4000 + 16'(i * 16'h0111);
      cycle();
    end
    wr = 0;
    wait_pos(2, 10, "wait_col2");
    req = 1; cycle(); req = 0; repeat (5) cycle();
    req = 1; cycle(); req = 0;
    wait_pos(4, 5, "wait_col4");
    req = 1; cycle(); req = 0;
    acks = 0;
    for (int i = 0; i < 2 * P_COLS * P_PER; i++) begin
      cycle();
      if (swap_ack) begin
        acks++;
        chk("ack_at_col0", 32'(frame_start), 32'd1);
      end
    end
    chk("ack_count", 32'(acks), 32'd1);

    // Write to column 2 on the very edge that performs the swap.
    wait_pos(P_COLS - 1, P_PER - 1, "wait_swap_edge");
    req = 1; wr = 1; addr = 3'd2; data = 16'hA5C3;
    cycle();
    req = 0; wr = 0;
    chk("swap_ack_w", 32'(swap_ack), 32'd1);
    wait_pos(2, 0, "wait_col2_shift");
    prev = disp.sclk; word = '0; rises = 0;
    for (int j = 1; j < P_SHIFT; j++) begin
      cycle();
      if (disp.sclk && !prev) begin word = {word[14:0], disp.sin}; rises++; end
      prev = disp.sclk;
    end
    chk("col2_word", 32'(word), 32'h0000A5C3);
    chk("col2_rises", 32'(rises), 32'(P_BITS));

    // Drop enable in the middle of bit 5.
    wait_pos(-1, 5 * 2 * P_DIV + 1, "wait_bit5");
    held_csel = disp.csel;
    en = 0; cycle();
    chk("dis_sclk",  32'(disp.sclk),  32'd0);
    chk("dis_sin",   32'(disp.sin),   32'd0);
    chk("dis_blank", 32'(disp.blank), 32'd1);
    chk("dis_latch", 32'(disp.latch), 32'd0);
    chk("dis_csel",  32'(disp.csel),  32'(held_csel));
    repeat (3) cycle();
    en = 1; cycle();
    chk("reen_fs",    32'(frame_start), 32'd1);
    chk("reen_blank", 32'(disp.blank),  32'd1);

    // Reset while latching with a swap still pending.
    wait_pos(1, 5, "wait_col1");
    req = 1; cycle(); req = 0;
    wait_pos(1, P_DWELL + 1, "wait_latch");
    rst = 1; cycle(); rst = 0;
    chk("rst_latch", 32'(disp.latch), 32'd0);
    chk("rst_blank", 32'(disp.blank), 32'd1);
    chk("rst_csel",  32'(disp.csel),  32'd0);
    acks = 0; sin_any = 0;
    for (int i = 0; i < P_COLS * P_PER + 10; i++) begin
      cycle();
      acks += int'(swap_ack);
      sin_any |= disp.sin;
    end
    chk("rst_no_ack", 32'(acks), 32'd0);
    chk("rst_buf_zero", 32'(sin_any), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 999) == 0);
      en   = ($urandom_range(0, 199) != 0);
      wr   = ($urandom_range(0, 3) == 0);
      addr = 3'($urandom_range(0, 7));
      data = 16'($urandom);
      req  = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
